fetch_reorder_buf: RTL

Parametrised in-order return buffer between the fetch PC generator and the instruction cache. Each fetch request pre-allocates an entry and receives its entry id. Up to `NUM_RSP` cache response ports fill entries out of order, and fetch packets drain to the instruction filter strictly in allocation order. On a frontend flush, outstanding entries are marked stale rather than reclaimed: late responses for them are absorbed and discarded, and an entry is never re-allocated while its old response is still owed.

---
 rtl/fetch_reorder_buf.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_reorder_buf.sv
// In-order return buffer between the fetch PC generator and the I-cache.
// Entries are pre-allocated in order, filled out of order by NUM_RSP response
// ports, and drained in allocation order. A flush marks still-owed entries
// stale so their late responses are absorbed instead of reaching the filter.
module fetch_reorder_buf #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_RSP = 2,
  parameter int unsigned ID_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_req,
  output logic                      alloc_gnt,
  output logic [ID_W-1:0]           alloc_id,
  input  logic [NUM_RSP-1:0]        rsp_vld,
  input  logic [NUM_RSP*ID_W-1:0]   rsp_id,
  input  logic [NUM_RSP*DATA_W-1:0] rsp_pld,
  input  logic [NUM_RSP-1:0]        rsp_err,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [DATA_W-1:0]         out_pld,
  output logic                      out_err,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      full,
  output logic [ID_W:0]             occupancy
);

  localparam logic [ID_W:0] DEPTH_CNT = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0] PTR_ONE   = (ID_W+1)'(1);

  logic [ID_W:0]       alloc_ptr;
  logic [ID_W:0]       rd_ptr;
  logic [DEPTH-1:0]    wait_q;
  logic [DEPTH-1:0]    stale_q;
  logic [DEPTH-1:0]    filled_q;
  logic [DEPTH-1:0]    err_q;
  logic [DATA_W-1:0]   pld_q [DEPTH];

  logic [ID_W-1:0]     alloc_idx;
  logic [ID_W-1:0]     rd_idx;
  logic                pop;
  logic [DEPTH-1:0]    gnt_mask;
  logic [DEPTH-1:0]    pop_mask;
  logic [DEPTH-1:0]    rsp_hit;
  logic [DEPTH-1:0]    wr_en;
  logic [DEPTH-1:0]    wr_err;
  logic [DATA_W-1:0]   wr_pld [DEPTH];
  logic                spurious;
  logic                collide;

  // Pointer-derived status, allocation handshake and head-of-queue outputs
  always_comb begin
    alloc_idx  = alloc_ptr[ID_W-1:0];
    rd_idx     = rd_ptr[ID_W-1:0];
    occupancy  = alloc_ptr - rd_ptr;
    full       = (occupancy == DEPTH_CNT);
    alloc_gnt  = alloc_req & ~full & ~wait_q[alloc_idx] & ~flush;
    alloc_id   = alloc_idx;
    out_vld    = filled_q[rd_idx] & ~flush;
    out_pld    = pld_q[rd_idx];
    out_err    = err_q[rd_idx];
    pop        = out_vld & out_rdy;
    flush_done = ~|stale_q;
    gnt_mask   = '0;
    pop_mask   = '0;
    gnt_mask[alloc_idx] = alloc_gnt;
    pop_mask[rd_idx]    = pop;
  end

  // Decode response ports into per-entry hit / write-enable / write-data
  always_comb begin
    rsp_hit  = '0;
    wr_en    = '0;
    wr_err   = '0;
    spurious = 1'b0;
    collide  = 1'b0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      wr_pld[e] = '0;
    end
    for (int unsigned p = 0; p < NUM_RSP; p++) begin
      if (rsp_vld[p]) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (rsp_id[p*ID_W +: ID_W] == ID_W'(e)) begin
            if (rsp_hit[e]) collide = 1'b1;
            rsp_hit[e] = 1'b1;
            if (!wait_q[e]) spurious = 1'b1;
            if (wait_q[e] && !stale_q[e] && !flush) begin
              wr_en[e]  = 1'b1;
              wr_pld[e] = rsp_pld[p*DATA_W +: DATA_W];
              wr_err[e] = rsp_err[p];
            end
          end
        end
      end
    end
  end

  // Pointer and per-entry state update; flush takes priority over grant/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      rd_ptr    <= '0;
      wait_q    <= '0;
      stale_q   <= '0;
      filled_q  <= '0;
      err_q     <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        pld_q[e] <= '0;
      end
    end else begin
      if (flush) begin
        rd_ptr   <= alloc_ptr;
        filled_q <= '0;
        // A response landing in the flush cycle settles its debt, so only
        // entries still owed afterwards become stale.
        wait_q   <= wait_q & ~rsp_hit;
        stale_q  <= wait_q & ~rsp_hit;
      end else begin
        if (alloc_gnt) alloc_ptr <= alloc_ptr + PTR_ONE;
        if (pop)       rd_ptr    <= rd_ptr + PTR_ONE;
        wait_q   <= (wait_q & ~rsp_hit) | gnt_mask;
        stale_q  <= stale_q & ~rsp_hit;
        filled_q <= (filled_q | wr_en) & ~pop_mask;
      end
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wr_en[e]) begin
          pld_q[e] <= wr_pld[e];
          err_q[e] <= wr_err[e];
        end
      end
    end
  end

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n) !spurious);
  a_no_rsp_collide:  assert property (@(posedge clk) disable iff (!rst_n) !collide);

endmodule
